// File: rtl/sr_button_driver.sv
// Debounced pushbutton front-end for an SR flip-flop: sync, debounce, edge detect, arbitrate.
// Reset wins a simultaneous press, so S and R are never driven high together.
module sr_button_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned EVT_W           = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             btn_set,
    input  logic             btn_rst,
    output logic             S,
    output logic             R,
    output logic             conflict,
    output logic [EVT_W-1:0] set_count,
    output logic [EVT_W-1:0] rst_count
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the set button, bit 1 the reset button.
    logic [1:0]            s1, s2, db, db_prev, rise;
    logic [1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1        <= '0;
            s2        <= '0;
            db        <= '0;
            db_prev   <= '0;
            rise      <= '0;
            cnt       <= '0;
            S         <= 1'b0;
            R         <= 1'b0;
            conflict  <= 1'b0;
            set_count <= '0;
            rst_count <= '0;
        end else begin
            s1      <= {btn_rst, btn_set};
            s2      <= s1;
            db_prev <= db;
            // Edge is registered before arbitration; this stage sets the D+3 press latency.
            rise    <= db & ~db_prev;

            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntMax) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end

            S         <= rise[0] & ~rise[1];
            R         <= rise[1];
            conflict  <= rise[0] & rise[1];
            set_count <= set_count + EVT_W'(S);
            rst_count <= rst_count + EVT_W'(R);
        end
    end

endmodule
